// File: rtl/jtdd_vram_arb_pkg.sv
// rtl/jtdd_vram_arb_pkg.sv - shared owner tags and CPU FSM states for the VRAM arbiter
package jtdd_vram_arb_pkg;

    typedef enum logic [2:0] {
        OWN_NONE = 3'd0,
        OWN_CHAR = 3'd1,
        OWN_SCR  = 3'd2,
        OWN_OBJ  = 3'd3,
        OWN_CPU  = 3'd4
    } owner_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        ACC  = 2'd2,
        HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/jtdd_vram_arb_if.sv
// rtl/jtdd_vram_arb_if.sv - CPU access bus into the VRAM arbiter
interface jtdd_vram_arb_if #(
    parameter int AW = 13,
    parameter int DW = 8
);
    logic          cpu_cs;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_dout;
    logic [DW-1:0] cpu_din;
    logic          cpu_wait;

    modport master (
        output cpu_cs, cpu_we, cpu_addr, cpu_dout,
        input  cpu_din, cpu_wait
    );

    modport slave (
        input  cpu_cs, cpu_we, cpu_addr, cpu_dout,
        output cpu_din, cpu_wait
    );
endinterface

// File: rtl/jtdd_vram_arb_slot.sv
// rtl/jtdd_vram_arb_slot.sv - combinational slot owner decode from bus phase and CPU state
module jtdd_vram_arb_slot
    import jtdd_vram_arb_pkg::*;
(
    input  logic [5:0] m,
    input  logic       vbl,
    input  logic       pending,
    input  logic       steal,
    output owner_t     owner,
    output logic       skip
);
    always_comb begin
        owner = OWN_CPU;
        skip  = 1'b0;
        if (!vbl) begin
            if (m[0]) begin
                owner = OWN_CHAR;
            end else if (m[2]) begin
                owner = OWN_SCR;
            end else if (m[4]) begin
                if (steal) begin
                    skip = 1'b1;
                end else begin
                    owner = OWN_OBJ;
                end
            end
        end
        if (owner == OWN_CPU && !pending) begin
            owner = OWN_NONE;
        end
    end
endmodule

// File: rtl/jtdd_vram_arb.sv
// rtl/jtdd_vram_arb.sv - VRAM time-slot arbiter: CPU FSM, address mux, owner pipeline, data capture
module jtdd_vram_arb
    import jtdd_vram_arb_pkg::*;
#(
    parameter int AW      = 13,
    parameter int DW      = 8,
    parameter int MAXWAIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pxl_cen,
    input  logic [5:0]    M,
    input  logic          VBL,
    jtdd_vram_arb_if.slave cpu,
    input  logic [AW-1:0] char_addr,
    input  logic [AW-1:0] scr_addr,
    input  logic [AW-1:0] obj_addr,
    output logic [DW-1:0] char_data,
    output logic [DW-1:0] scr_data,
    output logic [DW-1:0] obj_data,
    output logic          char_ok,
    output logic          scr_ok,
    output logic          obj_ok,
    output logic          obj_skip,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);
    localparam int CW = $clog2(MAXWAIT + 1);

    state_t        st, st_nx;
    owner_t        owner, own1, own2;
    logic [CW-1:0] cnt;
    logic          pending, steal, skip;
    logic [1:0]    gap;

    assign pending      = (st == PEND) && cpu.cpu_cs;
    assign steal        = pending && (cnt == CW'(MAXWAIT));
    assign cpu.cpu_wait = cpu.cpu_cs && (st != HOLD);

    jtdd_vram_arb_slot u_slot (
        .m       (M),
        .vbl     (VBL),
        .pending (pending),
        .steal   (steal),
        .owner   (owner),
        .skip    (skip)
    );

    always_comb begin
        st_nx = st;
        case (st)
            IDLE: if (cpu.cpu_cs) st_nx = PEND;
            PEND: begin
                if (!cpu.cpu_cs) st_nx = IDLE;
                else if (pxl_cen && owner == OWN_CPU) st_nx = ACC;
            end
            // ram_we is only high at E1 for a CPU write; reads finish when their tag reaches stage 2
            ACC:  if (ram_we || own2 == OWN_CPU) st_nx = HOLD;
            HOLD: if (!cpu.cpu_cs) st_nx = IDLE;
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st          <= IDLE;
            cnt         <= '0;
            own1        <= OWN_NONE;
            own2        <= OWN_NONE;
            ram_addr    <= '0;
            ram_we      <= 1'b0;
            ram_din     <= '0;
            char_data   <= '0;
            scr_data    <= '0;
            obj_data    <= '0;
            char_ok     <= 1'b0;
            scr_ok      <= 1'b0;
            obj_ok      <= 1'b0;
            obj_skip    <= 1'b0;
            cpu.cpu_din <= '0;
        end else begin
            st       <= st_nx;
            ram_we   <= 1'b0;
            char_ok  <= 1'b0;
            scr_ok   <= 1'b0;
            obj_ok   <= 1'b0;
            obj_skip <= 1'b0;
            own1     <= OWN_NONE;
            own2     <= own1;

            if (st == IDLE && cpu.cpu_cs) begin
                cnt <= '0;
            end else if (pending && pxl_cen && cnt != CW'(MAXWAIT)) begin
                cnt <= cnt + CW'(1);
            end

            if (pxl_cen) begin
                own1     <= owner;
                obj_skip <= skip;
                case (owner)
                    OWN_CHAR: ram_addr <= char_addr;
                    OWN_SCR:  ram_addr <= scr_addr;
                    OWN_OBJ:  ram_addr <= obj_addr;
                    OWN_CPU: begin
                        ram_addr <= cpu.cpu_addr;
                        ram_din  <= cpu.cpu_dout;
                        ram_we   <= cpu.cpu_we;
                    end
                    default: ;
                endcase
            end

            case (own2)
                OWN_CHAR: begin char_data <= ram_dout; char_ok <= 1'b1; end
                OWN_SCR:  begin scr_data  <= ram_dout; scr_ok  <= 1'b1; end
                OWN_OBJ:  begin obj_data  <= ram_dout; obj_ok  <= 1'b1; end
                OWN_CPU:  if (st == ACC) cpu.cpu_din <= ram_dout;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) gap <= 2'd3;
        else if (pxl_cen) gap <= 2'd0;
        else if (gap != 2'd3) gap <= gap + 2'd1;
    end

    a_m_onehot: assert property (@(posedge clk) disable iff (rst) pxl_cen |-> $onehot0(M));
    a_cen_gap:  assert property (@(posedge clk) disable iff (rst) pxl_cen |-> gap >= 2'd2);
endmodule

// File: tb/tb_jtdd_vram_arb.sv
// tb/tb_jtdd_vram_arb.sv - directed self-checking bench for jtdd_vram_arb
module tb_jtdd_vram_arb;
    import jtdd_vram_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst, pxl_cen, VBL;
    logic [5:0]  M;
    logic [12:0] char_addr, scr_addr, obj_addr, ram_addr;
    logic [7:0]  char_data, scr_data, obj_data, ram_din, ram_dout;
    logic        char_ok, scr_ok, obj_ok, obj_skip, ram_we;
    int          checks = 0, failures = 0;
    int          n_char = 0, n_scr = 0, n_obj = 0, n_skip = 0, n_we = 0;

    jtdd_vram_arb_if #(.AW(13), .DW(8)) cpu_bus ();

    jtdd_vram_arb #(.AW(13), .DW(8), .MAXWAIT(2)) dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .M(M), .VBL(VBL), .cpu(cpu_bus),
        .char_addr(char_addr), .scr_addr(scr_addr), .obj_addr(obj_addr),
        .char_data(char_data), .scr_data(scr_data), .obj_data(obj_data),
        .char_ok(char_ok), .scr_ok(scr_ok), .obj_ok(obj_ok), .obj_skip(obj_skip),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pre(input logic [12:0] a);
        return a[7:0] ^ {3'b000, a[12:8]} ^ 8'hA5;
    endfunction

    logic [7:0] mem [0:8191];
    bit         wr  [0:8191];
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_din;
            wr[ram_addr]  <= 1'b1;
        end
        ram_dout <= wr[ram_addr] ? mem[ram_addr] : pre(ram_addr);
    end

    always @(negedge clk) begin
        if (char_ok)  n_char++;
        if (scr_ok)   n_scr++;
        if (obj_ok)   n_obj++;
        if (obj_skip) n_skip++;
        if (ram_we)   n_we++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [5:0] m, input logic v);
        M = m; VBL = v; pxl_cen = 1'b1;
        @(negedge clk);
        pxl_cen = 1'b0; M = '0;
    endtask

    task automatic slot(input logic [5:0] m, input logic v);
        pulse(m, v);
        idle(5);
    endtask

    task automatic cpu_req(input logic we, input logic [12:0] a, input logic [7:0] d);
        cpu_bus.cpu_cs = 1'b1; cpu_bus.cpu_we = we; cpu_bus.cpu_addr = a; cpu_bus.cpu_dout = d;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(2);
        checks++; if ({ram_we, ram_addr, ram_din} !== 22'd0) begin failures++;
            $display("FAIL reset_ram: got we=%b addr=%h din=%h want 0", ram_we, ram_addr, ram_din); end
        checks++; if ({char_ok, scr_ok, obj_ok, obj_skip} !== 4'd0) begin failures++;
            $display("FAIL reset_strobes: got %b want 0000", {char_ok, scr_ok, obj_ok, obj_skip}); end
        checks++; if ({char_data, scr_data, obj_data, cpu_bus.cpu_din} !== 32'd0) begin failures++;
            $display("FAIL reset_data: got %h want 0", {char_data, scr_data, obj_data, cpu_bus.cpu_din}); end
        checks++; if (cpu_bus.cpu_wait !== 1'b0 || dut.st !== IDLE) begin failures++;
            $display("FAIL reset_fsm: got wait=%b st=%0d want 0/IDLE", cpu_bus.cpu_wait, dut.st); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_fetch;
        int c0, s0, o0, w0, k0;
        for (int seg = 0; seg < 2; seg++) begin
            char_addr = 13'(13'h0040 + seg);
            scr_addr  = 13'(13'h0800 + 3 * seg);
            obj_addr  = 13'(13'h1F00 + 5 * seg);
            c0 = n_char; s0 = n_scr; o0 = n_obj; w0 = n_we; k0 = n_skip;
            for (int i = 0; i < 6; i++) slot(6'(1 << i), 1'b0);
            checks++; if ({n_char - c0, n_scr - s0, n_obj - o0} !== {32'd1, 32'd1, 32'd1}) begin failures++;
                $display("FAIL fetch_ok_count seg%0d: got %0d/%0d/%0d want 1/1/1", seg, n_char - c0, n_scr - s0, n_obj - o0); end
            checks++; if (n_we != w0 || n_skip != k0) begin failures++;
                $display("FAIL fetch_no_cpu seg%0d: got we=%0d skip=%0d want 0/0", seg, n_we - w0, n_skip - k0); end
            checks++; if (char_data !== pre(char_addr)) begin failures++;
                $display("FAIL fetch_char seg%0d: got %h want %h", seg, char_data, pre(char_addr)); end
            checks++; if (scr_data !== pre(scr_addr)) begin failures++;
                $display("FAIL fetch_scr seg%0d: got %h want %h", seg, scr_data, pre(scr_addr)); end
            checks++; if (obj_data !== pre(obj_addr)) begin failures++;
                $display("FAIL fetch_obj seg%0d: got %h want %h", seg, obj_data, pre(obj_addr)); end
            checks++; if (ram_addr !== obj_addr) begin failures++;
                $display("FAIL fetch_addr_hold seg%0d: got %h want %h", seg, ram_addr, obj_addr); end
        end
    endtask

    task automatic test_cpu_write;
        int w0 = n_we;
        cpu_req(1'b1, 13'h0123, 8'h5A);
        idle(1);
        slot(6'h01, 1'b0);
        checks++; if (cpu_bus.cpu_wait !== 1'b1 || n_we != w0) begin failures++;
            $display("FAIL wr_char_slot: got wait=%b we=%0d want 1/0", cpu_bus.cpu_wait, n_we - w0); end
        slot(6'h04, 1'b0);
        pulse(6'h08, 1'b0);
        checks++; if ({ram_we, ram_addr, ram_din, cpu_bus.cpu_wait} !== {1'b1, 13'h0123, 8'h5A, 1'b1}) begin failures++;
            $display("FAIL wr_issue: got we=%b addr=%h din=%h wait=%b want 1/0123/5a/1", ram_we, ram_addr, ram_din, cpu_bus.cpu_wait); end
        idle(1);
        checks++; if (ram_we !== 1'b0 || cpu_bus.cpu_wait !== 1'b0) begin failures++;
            $display("FAIL wr_e1: got we=%b wait=%b want 0/0", ram_we, cpu_bus.cpu_wait); end
        idle(4); cpu_bus.cpu_cs = 1'b0; idle(1);
        cpu_req(1'b0, 13'h0123, 8'h00);
        idle(1);
        pulse(6'h02, 1'b0);
        idle(2);
        checks++; if (cpu_bus.cpu_wait !== 1'b0 || cpu_bus.cpu_din !== 8'h5A) begin failures++;
            $display("FAIL wr_readback: got wait=%b din=%h want 0/5a", cpu_bus.cpu_wait, cpu_bus.cpu_din); end
        idle(3); cpu_bus.cpu_cs = 1'b0; idle(1);
        checks++; if (n_we - w0 != 1) begin failures++;
            $display("FAIL wr_we_count: got %0d want 1", n_we - w0); end
    endtask

    task automatic test_vbl_burst;
        logic [12:0] a [4];
        logic [5:0]  ms [4];
        logic [7:0]  exp;
        int s0 = n_char + n_scr + n_obj + n_skip;
        a[0] = 13'h0123; a[1] = 13'h0050; a[2] = 13'h1FFF; a[3] = 13'h0000;
        ms[0] = 6'h01; ms[1] = 6'h04; ms[2] = 6'h10; ms[3] = 6'h02;
        cpu_req(1'b0, a[0], 8'h00);
        idle(2);
        for (int k = 0; k < 4; k++) begin
            exp = (k == 0) ? 8'h5A : pre(a[k]);
            pulse(ms[k], 1'b1);
            idle(2);
            checks++; if (cpu_bus.cpu_wait !== 1'b0 || cpu_bus.cpu_din !== exp) begin failures++;
                $display("FAIL vbl_read%0d: got wait=%b din=%h want 0/%h", k, cpu_bus.cpu_wait, cpu_bus.cpu_din, exp); end
            cpu_bus.cpu_cs = 1'b0;
            idle(1);
            if (k < 3) begin
                cpu_req(1'b0, a[k + 1], 8'h00);
                idle(2);
            end else begin
                idle(3);
            end
        end
        checks++; if (n_char + n_scr + n_obj + n_skip != s0) begin failures++;
            $display("FAIL vbl_strobes: got %0d want 0", n_char + n_scr + n_obj + n_skip - s0); end
        VBL = 1'b0;
    endtask

    task automatic test_obj_steal;
        int o0 = n_obj, k0 = n_skip;
        cpu_req(1'b1, 13'h0400, 8'h3C);
        idle(1);
        slot(6'h04, 1'b0);
        slot(6'h10, 1'b0);
        checks++; if (n_obj - o0 != 1 || n_skip != k0 || cpu_bus.cpu_wait !== 1'b1) begin failures++;
            $display("FAIL steal_early: got obj=%0d skip=%0d wait=%b want 1/0/1", n_obj - o0, n_skip - k0, cpu_bus.cpu_wait); end
        pulse(6'h10, 1'b0);
        checks++; if ({obj_skip, ram_we, ram_addr} !== {1'b1, 1'b1, 13'h0400}) begin failures++;
            $display("FAIL steal_issue: got skip=%b we=%b addr=%h want 1/1/0400", obj_skip, ram_we, ram_addr); end
        idle(5);
        checks++; if (n_obj - o0 != 1 || n_skip - k0 != 1) begin failures++;
            $display("FAIL steal_strobes: got obj=%0d skip=%0d want 1/1", n_obj - o0, n_skip - k0); end
        checks++; if (obj_data !== pre(obj_addr) || cpu_bus.cpu_wait !== 1'b0) begin failures++;
            $display("FAIL steal_hold: got obj_data=%h wait=%b want %h/0", obj_data, cpu_bus.cpu_wait, pre(obj_addr)); end
        cpu_bus.cpu_cs = 1'b0; idle(1);
    endtask

    task automatic test_cancel_hold;
        int w0 = n_we;
        cpu_req(1'b1, 13'h0777, 8'h11);
        idle(1);
        slot(6'h01, 1'b0);
        cpu_bus.cpu_cs = 1'b0;
        idle(1);
        checks++; if (dut.st !== IDLE) begin failures++;
            $display("FAIL cancel_state: got %0d want IDLE", dut.st); end
        slot(6'h02, 1'b0);
        checks++; if (n_we != w0) begin failures++;
            $display("FAIL cancel_no_we: got %0d want 0", n_we - w0); end
        cpu_req(1'b1, 13'h0778, 8'h22);
        idle(1);
        slot(6'h02, 1'b0);
        slot(6'h02, 1'b0);
        slot(6'h08, 1'b0);
        checks++; if (n_we - w0 != 1 || cpu_bus.cpu_wait !== 1'b0 || dut.st !== HOLD) begin failures++;
            $display("FAIL hold_single: got we=%0d wait=%b st=%0d want 1/0/HOLD", n_we - w0, cpu_bus.cpu_wait, dut.st); end
        cpu_bus.cpu_cs = 1'b0;
        idle(1);
        checks++; if (dut.st !== IDLE) begin failures++;
            $display("FAIL hold_release: got %0d want IDLE", dut.st); end
    endtask

    task automatic test_reset_mid;
        int s0;
        cpu_req(1'b1, 13'h0100, 8'h77);
        idle(1);
        pulse(6'h02, 1'b0);
        checks++; if (ram_we !== 1'b1) begin failures++;
            $display("FAIL rstmid_acc: got we=%b want 1", ram_we); end
        rst = 1'b1; cpu_bus.cpu_cs = 1'b0;
        #1;
        checks++; if (ram_we !== 1'b0 || cpu_bus.cpu_wait !== 1'b0) begin failures++;
            $display("FAIL rstmid_async: got we=%b wait=%b want 0/0", ram_we, cpu_bus.cpu_wait); end
        s0 = n_char + n_scr + n_obj + n_skip + n_we;
        @(negedge clk);
        rst = 1'b0;
        idle(5);
        checks++; if (n_char + n_scr + n_obj + n_skip + n_we != s0) begin failures++;
            $display("FAIL rstmid_silent: got %0d strobes want 0", n_char + n_scr + n_obj + n_skip + n_we - s0); end
        cpu_req(1'b0, 13'h0100, 8'h00);
        idle(1);
        pulse(6'h02, 1'b0);
        idle(2);
        checks++; if (cpu_bus.cpu_wait !== 1'b0 || cpu_bus.cpu_din !== pre(13'h0100)) begin failures++;
            $display("FAIL rstmid_nowrite: got wait=%b din=%h want 0/%h", cpu_bus.cpu_wait, cpu_bus.cpu_din, pre(13'h0100)); end
        cpu_bus.cpu_cs = 1'b0;
        idle(2);
    endtask

    initial begin
        rst = 1'b1; pxl_cen = 1'b0; VBL = 1'b0; M = '0;
        char_addr = '0; scr_addr = '0; obj_addr = '0;
        cpu_bus.cpu_cs = 1'b0; cpu_bus.cpu_we = 1'b0; cpu_bus.cpu_addr = '0; cpu_bus.cpu_dout = '0;
        test_reset();
        test_fetch();
        test_cpu_write();
        test_vbl_burst();
        test_obj_steal();
        test_cancel_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
